// File: rtl/furv_dmem.sv
// furv_dmem: single-port word-addressed data memory for the FURV core.
// A request (mem) is accepted from IDLE, optionally stretched through
// WAIT_STATES cycles in WAIT, and completed with a one-cycle ack in RESP.
// The array access (byte-lane write or full-word read) happens on the
// edge that enters RESP.
//
// Optional feature macro: FURV_DMEM_ERR_EN
//   defined   -> err port present; addresses >= DEPTH_WORDS complete with
//                ack and err, writes are dropped and reads return zero.
//   undefined -> no err port; the address wraps modulo DEPTH_WORDS.
module furv_dmem #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem,
    input  logic        mem_write,
    input  logic [29:0] addr,
    input  logic [3:0]  sel,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ack
`ifdef FURV_DMEM_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state_q;
    logic [3:0]    cnt_q;
    logic          ack_q;
    logic [31:0]   rdata_q;
    logic [31:0]   mem_array_q [DEPTH_WORDS];

    logic [AW-1:0] index;
    logic          in_range;
    logic          access_go;

`ifdef FURV_DMEM_ERR_EN
    logic          err_q;
`else
    logic          unused_addr_bits;
`endif

    // Word index and range qualification of the current address.
    always_comb begin
        index = addr[AW-1:0];
`ifdef FURV_DMEM_ERR_EN
        in_range = ({2'b00, addr} < 32'(DEPTH_WORDS));
`else
        in_range         = 1'b1;
        unused_addr_bits = ^addr[29:AW];
`endif
    end

    // Strobe marking the edge that moves the FSM into RESP: the access edge.
    always_comb begin
        access_go = 1'b0;
        case (state_q)
            IDLE:    access_go = mem && (WAIT_STATES == 0);
            WAIT:    access_go = mem && (cnt_q == 4'd0);
            default: access_go = 1'b0;
        endcase
    end

    // Byte-lane write into the array; deliberately outside the reset domain
    // so that reset never disturbs stored contents.
    always_ff @(posedge clk) begin
        if (access_go && mem_write && in_range) begin
            for (int n = 0; n < 4; n++) begin
                if (sel[n]) begin
                    mem_array_q[index][8*n +: 8] <= wdata[8*n +: 8];
                end
            end
        end
    end

    // Request FSM with registered ack, rdata and err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ack_q   <= 1'b0;
            rdata_q <= 32'h0;
`ifdef FURV_DMEM_ERR_EN
            err_q   <= 1'b0;
`endif
        end else begin
            ack_q <= 1'b0;
`ifdef FURV_DMEM_ERR_EN
            err_q <= 1'b0;
`endif
            if (access_go) begin
                ack_q <= 1'b1;
`ifdef FURV_DMEM_ERR_EN
                err_q <= !in_range;
`endif
                if (!mem_write) begin
                    rdata_q <= in_range ? mem_array_q[index] : 32'h0;
                end
            end
            case (state_q)
                IDLE: begin
                    if (mem) begin
                        if (WAIT_STATES == 0) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (!mem) begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 4'd0;
                end
            endcase
        end
    end

    assign ack   = ack_q;
    assign rdata = rdata_q;
`ifdef FURV_DMEM_ERR_EN
    assign err   = err_q;
`endif

endmodule

// File: tb/tb_furv_dmem.sv
// tb_furv_dmem: directed bench for furv_dmem. Two instances share clock
// and reset: u0 with no wait states and u3 with three wait states.
module tb_furv_dmem;

    logic        clk;
    logic        rst;

    logic        m0, we0, ack0, err0;
    logic [29:0] a0;
    logic [3:0]  s0;
    logic [31:0] d0, rd0;

    logic        m3, we3, ack3, err3;
    logic [29:0] a3;
    logic [3:0]  s3;
    logic [31:0] d3, rd3;

    int checks = 0;
    int errors = 0;

    furv_dmem #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u0 (
        .clk(clk), .rst(rst), .mem(m0), .mem_write(we0), .addr(a0),
        .sel(s0), .wdata(d0), .rdata(rd0), .ack(ack0)
`ifdef FURV_DMEM_ERR_EN
        , .err(err0)
`endif
    );

    furv_dmem #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u3 (
        .clk(clk), .rst(rst), .mem(m3), .mem_write(we3), .addr(a3),
        .sel(s3), .wdata(d3), .rdata(rd3), .ack(ack3)
`ifdef FURV_DMEM_ERR_EN
        , .err(err3)
`endif
    );

`ifndef FURV_DMEM_ERR_EN
    assign err0 = 1'b0;
    assign err3 = 1'b0;
`endif

    // Free-running 10-time-unit clock; rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something never returns.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // One comparison: counts, asserts and reports on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request on the selected instance, hold mem until ack is seen,
    // then drop it. Returns latency in cycles (-1 on timeout), rdata and err.
    task automatic applyStimulus(input bit inst, input logic we, input logic [29:0] a,
                                 input logic [3:0] s, input logic [31:0] d,
                                 output int lat, output logic [31:0] rd, output logic e);
        @(negedge clk);
        if (!inst) begin
            m0 = 1'b1; we0 = we; a0 = a; s0 = s; d0 = d;
        end else begin
            m3 = 1'b1; we3 = we; a3 = a; s3 = s; d3 = d;
        end
        lat = -1;
        rd  = 32'hx;
        e   = 1'bx;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if ((!inst && ack0) || (inst && ack3)) begin
                lat = c;
                rd  = inst ? rd3 : rd0;
                e   = inst ? err3 : err0;
                break;
            end
        end
        if (!inst) m0 = 1'b0;
        else       m3 = 1'b0;
    endtask

    // Directed sequence.
    initial begin
        int          lat;
        logic [31:0] rd;
        logic        e;
        int          cyc, prev, acks, cnt;
        logic [31:0] lastW;
        logic        curWe;
        bit          got;

        rst = 1'b1;
        m0 = 0; we0 = 0; a0 = 0; s0 = 0; d0 = 0;
        m3 = 0; we3 = 0; a3 = 0; s3 = 0; d3 = 0;

        // Reset values, checked before any clock edge.
        #1;
        checkOutput("rstAck0", 32'(ack0), 32'd0);
        checkOutput("rstRd0", rd0, 32'h0);
        checkOutput("rstAck3", 32'(ack3), 32'd0);
        checkOutput("rstRd3", rd3, 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Basic full-word write then read, no wait states.
        applyStimulus(0, 1, 30'd5, 4'b1111, 32'hDEADBEEF, lat, rd, e);
        checkOutput("wr5Lat", 32'(lat), 32'd1);
        applyStimulus(0, 0, 30'd5, 4'b1111, 32'h0, lat, rd, e);
        checkOutput("rd5Lat", 32'(lat), 32'd1);
        checkOutput("rd5Data", rd, 32'hDEADBEEF);

        // Partial write of lane 1.
        applyStimulus(0, 1, 30'd5, 4'b0010, 32'h0000AA00, lat, rd, e);
        checkOutput("partLat", 32'(lat), 32'd1);
        applyStimulus(0, 0, 30'd5, 4'b1111, 32'h0, lat, rd, e);
        checkOutput("partData", rd, 32'hDEADAAEF);

        // Write with no lanes enabled acks but changes nothing; rdata holds.
        applyStimulus(0, 1, 30'd5, 4'b0000, 32'hFFFFFFFF, lat, rd, e);
        checkOutput("sel0Lat", 32'(lat), 32'd1);
        checkOutput("rdHoldWr", rd, 32'hDEADAAEF);
        applyStimulus(0, 0, 30'd5, 4'b1111, 32'h0, lat, rd, e);
        checkOutput("sel0Data", rd, 32'hDEADAAEF);

        // Out-of-range address 1029 on a 1024-word array.
        applyStimulus(0, 1, 30'd1029, 4'b1111, 32'h12345678, lat, rd, e);
        checkOutput("oorLat", 32'(lat), 32'd1);
`ifdef FURV_DMEM_ERR_EN
        checkOutput("oorErr", 32'(e), 32'd1);
        applyStimulus(0, 0, 30'd5, 4'b1111, 32'h0, lat, rd, e);
        checkOutput("oorRd5", rd, 32'hDEADAAEF);
        checkOutput("oorErrOk", 32'(e), 32'd0);
        applyStimulus(0, 0, 30'd1029, 4'b1111, 32'h0, lat, rd, e);
        checkOutput("oorRdZero", rd, 32'h0);
        checkOutput("oorRdErr", 32'(e), 32'd1);
`else
        applyStimulus(0, 0, 30'd5, 4'b1111, 32'h0, lat, rd, e);
        checkOutput("aliasRd5", rd, 32'h12345678);
`endif

        // Back-to-back alternating write/read to word 9 with mem held high.
        @(negedge clk);
        m0 = 1'b1; we0 = 1'b1; a0 = 30'd9; s0 = 4'b1111; d0 = 32'hA5000000;
        curWe = 1'b1;
        lastW = 32'h0;
        acks = 0; cyc = 0; prev = 0;
        for (int i = 0; i < 8; i++) begin
            got = 0;
            for (int c = 0; c < 40 && !got; c++) begin
                @(negedge clk);
                cyc++;
                if (ack0) got = 1;
            end
            checkOutput("b2bAck", 32'(ack0), 32'd1);
            if (ack0) acks++;
            if (i > 0) checkOutput("b2bGap", 32'(cyc - prev), 32'd2);
            prev = cyc;
            if (curWe) lastW = d0;
            else       checkOutput("b2bRead", rd0, lastW);
            if (i < 7) begin
                curWe = ((i + 1) % 2 == 0);
                we0   = curWe;
                d0    = 32'hA5000000 | 32'(i + 1);
            end else begin
                m0 = 1'b0;
            end
        end
        checkOutput("b2bCount", 32'(acks), 32'd8);

        // Three wait states: latency 4 and a single-cycle ack.
        applyStimulus(1, 1, 30'd7, 4'b1111, 32'h11112222, lat, rd, e);
        checkOutput("ws3WrLat", 32'(lat), 32'd4);
        applyStimulus(1, 0, 30'd7, 4'b1111, 32'h0, lat, rd, e);
        checkOutput("ws3RdLat", 32'(lat), 32'd4);
        checkOutput("ws3RdData", rd, 32'h11112222);
        @(negedge clk);
        checkOutput("ws3AckWidth", 32'(ack3), 32'd0);
        applyStimulus(1, 1, 30'd8, 4'b1111, 32'h33334444, lat, rd, e);
        checkOutput("ws3Wr8Lat", 32'(lat), 32'd4);

        // Abort a read of word 8 by dropping mem while in WAIT.
        @(negedge clk);
        m3 = 1'b1; we3 = 1'b0; a3 = 30'd8;
        repeat (2) @(negedge clk);
        m3 = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack3) cnt++;
        end
        checkOutput("abortNoAck", 32'(cnt), 32'd0);
        checkOutput("abortRdHold", rd3, 32'h11112222);

        // Reset pulsed during WAIT of a write to word 7.
        @(negedge clk);
        m3 = 1'b1; we3 = 1'b1; a3 = 30'd7; s3 = 4'b1111; d3 = 32'hDEADDEAD;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midRstAck", 32'(ack3), 32'd0);
        checkOutput("midRstRd", rd3, 32'h0);
        @(negedge clk);
        m3 = 1'b0;
        rst = 1'b0;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (ack3) cnt++;
        end
        checkOutput("midRstNoAck", 32'(cnt), 32'd0);
        applyStimulus(1, 0, 30'd7, 4'b1111, 32'h0, lat, rd, e);
        checkOutput("midRstRdLat", 32'(lat), 32'd4);
        checkOutput("midRstOld", rd, 32'h11112222);

        // Array contents in u0 survive the reset.
        applyStimulus(0, 0, 30'd9, 4'b1111, 32'h0, lat, rd, e);
        checkOutput("keepAfterRst", rd, 32'hA5000006);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
